// File: rtl/motor_pwm_array.sv
// motor_pwm_array
//   N-channel H-bridge PWM driver. Each channel runs COAST / DRIVE / BRAKE with
//   a per-channel duty and direction. Commands arrive over a valid/ready port
//   into shadow registers. They are copied to the active set only at PWM period
//   boundaries, so outputs never glitch mid-period. Reversals and DRIVE<->BRAKE
//   changes pass through a DEAD interval with both sides off.
//
// Ports
//   osc_clk       system clock
//   rstn          asynchronous, active-low reset
//   cmd_valid     command strobe
//   cmd_ready     command accepted when cmd_valid && cmd_ready
//   cmd_ch        target channel index
//   cmd_duty      duty compare value
//   cmd_dir       0 = PWM on neg_motor, 1 = PWM on pos_motor
//   cmd_mode      00 COAST, 01 DRIVE, 10 BRAKE, 11 COAST
//   cmd_err       1-cycle pulse after a command with cmd_ch >= N_CH
//   period_start  1-cycle pulse in the cycle after each boundary tick
//   pos_motor     high-side drive, registered
//   neg_motor     low-side drive, registered
module motor_pwm_array #(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned CTR_LEN    = 8,
  parameter int unsigned PRESCALE   = 4,
  parameter int unsigned DEAD_TICKS = 2
) (
  input  logic               osc_clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_ch,
  input  logic [CTR_LEN-1:0] cmd_duty,
  input  logic               cmd_dir,
  input  logic [1:0]         cmd_mode,
  output logic               cmd_err,
  output logic               period_start,
  output logic [N_CH-1:0]    pos_motor,
  output logic [N_CH-1:0]    neg_motor
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    M_COAST  = 2'b00,
    M_DRIVE  = 2'b01,
    M_BRAKE  = 2'b10,
    M_COAST2 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_COAST,
    S_DRIVE,
    S_BRAKE,
    S_DEAD
  } ch_state_e;

  // ---------------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------------
  logic [PW-1:0]      presc_q;
  logic [CTR_LEN-1:0] ctr_q;
  logic [CTR_LEN-1:0] ctr_d;
  logic               tick;
  logic               boundary;

  assign tick     = (presc_q == PW'(PRESCALE - 1));
  assign boundary = tick && (ctr_q == '1);
  assign ctr_d    = tick ? ctr_q + CTR_LEN'(1) : ctr_q;

  // ---------------------------------------------------------------------------
  // Command port
  // ---------------------------------------------------------------------------
  logic cmd_ready_q;
  logic cmd_err_q;
  logic period_start_q;
  logic cmd_acc;
  logic ch_ok;

  assign cmd_acc = cmd_valid && cmd_ready_q;
  assign ch_ok   = ({1'b0, cmd_ch} < 5'(N_CH));

  always_ff @(posedge osc_clk or negedge rstn) begin
    if (!rstn) begin
      presc_q        <= '0;
      ctr_q          <= '0;
      cmd_ready_q    <= 1'b0;
      cmd_err_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= tick ? '0 : presc_q + PW'(1);
      ctr_q          <= ctr_d;
      cmd_ready_q    <= 1'b1;
      cmd_err_q      <= cmd_acc && !ch_ok;
      period_start_q <= boundary;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow registers. A write landing on the boundary tick is not seen by the
  // active copy taken on that same edge, so it waits for the next boundary.
  // ---------------------------------------------------------------------------
  logic [CTR_LEN-1:0] sh_duty_q [N_CH];
  logic               sh_dir_q  [N_CH];
  logic [1:0]         sh_mode_q [N_CH];

  always_ff @(posedge osc_clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        sh_duty_q[i] <= '0;
        sh_dir_q[i]  <= 1'b0;
        sh_mode_q[i] <= M_COAST;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (cmd_acc && ch_ok && (cmd_ch == 4'(i))) begin
          sh_duty_q[i] <= cmd_duty;
          sh_dir_q[i]  <= cmd_dir;
          sh_mode_q[i] <= cmd_mode;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state machines
  // ---------------------------------------------------------------------------
  logic [CTR_LEN-1:0] act_duty_q [N_CH];
  logic               act_dir_q  [N_CH];
  logic [1:0]         act_mode_q [N_CH];
  ch_state_e          st_q       [N_CH];
  ch_state_e          st_d       [N_CH];
  logic [DW-1:0]      dead_q     [N_CH];
  logic [DW-1:0]      dead_d     [N_CH];
  logic [N_CH-1:0]    pos_d;
  logic [N_CH-1:0]    neg_d;
  logic [N_CH-1:0]    pos_q;
  logic [N_CH-1:0]    neg_q;

  // State entered at a boundary, given the running state and the new command.
  // DEAD holds its target in the active registers, so a DEAD channel behaves
  // like one already driving: any non-COAST command restarts the dead time.
  function automatic ch_state_e boundary_next(ch_state_e cur, logic cur_dir,
                                              logic [1:0] mode, logic dir);
    ch_state_e nxt;
    logic      need_dead;
    nxt       = S_COAST;
    need_dead = 1'b0;
    if (mode == M_DRIVE) begin
      nxt       = S_DRIVE;
      need_dead = (cur == S_DEAD) || (cur == S_BRAKE) ||
                  ((cur == S_DRIVE) && (dir != cur_dir));
    end else if (mode == M_BRAKE) begin
      nxt       = S_BRAKE;
      need_dead = (cur == S_DEAD) || (cur == S_DRIVE);
    end
    if (need_dead && (DEAD_TICKS != 0)) begin
      nxt = S_DEAD;
    end
    return nxt;
  endfunction

  // Returns {pos, neg}.
  function automatic logic [1:0] drive_out(ch_state_e st, logic dir,
                                           logic [CTR_LEN-1:0] duty,
                                           logic [CTR_LEN-1:0] ctr);
    logic [1:0] o;
    logic       pwm;
    o   = 2'b00;
    pwm = (ctr < duty);
    case (st)
      S_DRIVE: o = dir ? {pwm, 1'b0} : {1'b0, pwm};
      S_BRAKE: o = 2'b11;
      default: o = 2'b00;
    endcase
    return o;
  endfunction

  // Outputs are computed from next-state values so that the pins move on the
  // same edge as the boundary or compare-crossing tick, not one clock later.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      st_d[i]   = st_q[i];
      dead_d[i] = dead_q[i];
      if (boundary) begin
        st_d[i]   = boundary_next(st_q[i], act_dir_q[i], sh_mode_q[i], sh_dir_q[i]);
        dead_d[i] = DW'(DEAD_TICKS);
      end else if (tick && (st_q[i] == S_DEAD)) begin
        if (dead_q[i] <= DW'(1)) begin
          st_d[i] = (act_mode_q[i] == M_BRAKE) ? S_BRAKE : S_DRIVE;
        end else begin
          dead_d[i] = dead_q[i] - DW'(1);
        end
      end
      {pos_d[i], neg_d[i]} = drive_out(st_d[i],
                                       boundary ? sh_dir_q[i]  : act_dir_q[i],
                                       boundary ? sh_duty_q[i] : act_duty_q[i],
                                       ctr_d);
    end
  end

  always_ff @(posedge osc_clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        act_duty_q[i] <= '0;
        act_dir_q[i]  <= 1'b0;
        act_mode_q[i] <= M_COAST;
        st_q[i]       <= S_COAST;
        dead_q[i]     <= '0;
      end
      pos_q <= '0;
      neg_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (boundary) begin
          act_duty_q[i] <= sh_duty_q[i];
          act_dir_q[i]  <= sh_dir_q[i];
          act_mode_q[i] <= sh_mode_q[i];
        end
        st_q[i]   <= st_d[i];
        dead_q[i] <= dead_d[i];
      end
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign cmd_err      = cmd_err_q;
  assign period_start = period_start_q;
  assign pos_motor    = pos_q;
  assign neg_motor    = neg_q;

endmodule

// File: tb/tb_motor_pwm_array.sv
module tb_motor_pwm_array;

  localparam int NCH = 8;
  localparam int CL  = 8;
  localparam int P   = 4;
  localparam int DT  = 2;
  localparam int PER = P * 256;

  localparam int COAST = 0;
  localparam int DRIVE = 1;
  localparam int BRAKE = 2;

  logic           osc_clk = 1'b0;
  logic           rstn = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_ch = '0;
  logic [CL-1:0]  cmd_duty = '0;
  logic           cmd_dir = 1'b0;
  logic [1:0]     cmd_mode = '0;
  logic           cmd_err;
  logic           period_start;
  logic [NCH-1:0] pos_motor;
  logic [NCH-1:0] neg_motor;

  always #5 osc_clk = ~osc_clk;

  motor_pwm_array #(
    .N_CH(NCH), .CTR_LEN(CL), .PRESCALE(P), .DEAD_TICKS(DT)
  ) dut (
    .osc_clk(osc_clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode),
    .cmd_err(cmd_err), .period_start(period_start),
    .pos_motor(pos_motor), .neg_motor(neg_motor)
  );

  int n_chk, n_pass, n_fail;

  // Reference model: time is the number of clock edges j since reset release.
  // Ticks fall on edges with j % P == 0, ctr = (j / P) % 256, boundaries on
  // j % PER == 0. Dead time is an absolute window of edges.
  int j;
  int sh_duty [NCH], sh_dir [NCH], sh_mode [NCH];
  int m_kind [NCH], m_dir [NCH], m_duty [NCH];
  int dead_until [NCH];
  bit m_ready, m_err, m_ps;

  function automatic int kind_of(int mode);
    return (mode == 1) ? DRIVE : (mode == 2) ? BRAKE : COAST;
  endfunction

  task automatic model_reset();
    j = 0; m_ready = 0; m_err = 0; m_ps = 0;
    for (int c = 0; c < NCH; c++) begin
      sh_duty[c] = 0; sh_dir[c] = 0; sh_mode[c] = 0;
      m_kind[c] = COAST; m_dir[c] = 0; m_duty[c] = 0; dead_until[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit acc, bnd;
    int ch, nk;
    bit need_dead;
    if (!rstn) begin
      model_reset();
      return;
    end
    acc = cmd_valid && m_ready;
    ch  = int'(cmd_ch);
    j   = j + 1;
    bnd = (j % PER == 0);
    if (bnd) begin
      for (int c = 0; c < NCH; c++) begin
        nk = kind_of(sh_mode[c]);
        need_dead = (nk != COAST) &&
                    ((j <= dead_until[c]) ||
                     (m_kind[c] == DRIVE && nk == DRIVE && sh_dir[c] != m_dir[c]) ||
                     (m_kind[c] == DRIVE && nk == BRAKE) ||
                     (m_kind[c] == BRAKE && nk == DRIVE));
        m_kind[c] = nk; m_dir[c] = sh_dir[c]; m_duty[c] = sh_duty[c];
        dead_until[c] = (need_dead && DT > 0) ? j + DT * P : 0;
      end
    end
    if (acc && ch < NCH) begin
      sh_duty[ch] = int'(cmd_duty); sh_dir[ch] = int'(cmd_dir); sh_mode[ch] = int'(cmd_mode);
    end
    m_err   = acc && (ch >= NCH);
    m_ps    = bnd;
    m_ready = 1;
  endtask

  task automatic exp_outs(output logic [NCH-1:0] ep, output logic [NCH-1:0] en);
    int ctr;
    bit pwm;
    ctr = (j / P) % 256;
    ep = '0; en = '0;
    for (int c = 0; c < NCH; c++) begin
      pwm = (ctr < m_duty[c]);
      if (j >= dead_until[c]) begin
        if (m_kind[c] == BRAKE) begin
          ep[c] = 1'b1; en[c] = 1'b1;
        end else if (m_kind[c] == DRIVE) begin
          ep[c] = (m_dir[c] == 1) && pwm;
          en[c] = (m_dir[c] == 0) && pwm;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, j);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] ep, en;
    exp_outs(ep, en);
    chk("pos_motor", 32'(pos_motor), 32'(ep));
    chk("neg_motor", 32'(neg_motor), 32'(en));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
  endtask

  task automatic cycle();
    @(posedge osc_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input int ch, input int duty, input int dir, input int mode);
    cmd_valid = 1'b1;
    cmd_ch    = 4'(ch);
    cmd_duty  = CL'(duty);
    cmd_dir   = 1'(dir);
    cmd_mode  = 2'(mode);
    cycle();
    cmd_valid = 1'b0;
  endtask

  // Advance to just after the next boundary edge.
  task automatic align_boundary();
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while ((j % PER != 0) && (k <= PER + 1));
    chk("align_bound", 32'(j % PER), 32'd0);
  endtask

  task automatic align_pre_boundary();
    int k;
    k = 0;
    while ((j % PER != PER - 1) && (k <= PER + 1)) begin
      cycle();
      k++;
    end
    chk("align_pre", 32'(j % PER), 32'(PER - 1));
  endtask

  int hi, lo, ps, z;

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    model_reset();

    // Reset state
    #1 check_all();
    run(3);
    @(negedge osc_clk) rstn = 1'b1;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    cycle();
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // 1: ch0 DRIVE dir0 duty 64 -> 256 of 1024 clocks high on neg
    send(0, 64, 0, DRIVE);
    send(1, 128, 1, DRIVE);
    send(2, 50, 0, DRIVE);
    align_boundary();
    hi = 0; ps = 0; z = 0;
    repeat (PER) begin
      hi += int'(neg_motor[0]);
      z  += int'(pos_motor[0]);
      ps += int'(period_start);
      cycle();
    end
    chk("t1_neg0_high", 32'(hi), 32'd256);
    chk("t1_pos0_high", 32'(z), 32'd0);
    chk("t1_pstart_cnt", 32'(ps), 32'd1);

    // 2: ch1 reversal -> 8 clocks off, then 50% on neg
    send(1, 128, 0, DRIVE);
    align_boundary();
    z = 0;
    repeat (8) begin
      if (!pos_motor[1] && !neg_motor[1]) z++;
      cycle();
    end
    chk("t2_dead_zero", 32'(z), 32'd8);
    chk("t2_neg1_on", 32'(neg_motor[1]), 32'd1);
    chk("t2_pos1_off", 32'(pos_motor[1]), 32'd0);

    // 3: ch2 DRIVE -> BRAKE with dead time, then COAST immediately
    send(2, 0, 0, BRAKE);
    align_boundary();
    z = 0;
    repeat (8) begin
      if (!pos_motor[2] && !neg_motor[2]) z++;
      cycle();
    end
    chk("t3_dead_zero", 32'(z), 32'd8);
    chk("t3_brake", 32'({pos_motor[2], neg_motor[2]}), 32'd3);
    send(2, 0, 0, COAST);
    align_boundary();
    chk("t3_coast", 32'({pos_motor[2], neg_motor[2]}), 32'd0);

    // 4: last write wins; duty boundaries
    send(3, 10, 1, DRIVE);
    run(20);
    send(3, 20, 1, DRIVE);
    run(20);
    send(3, 30, 1, DRIVE);
    align_boundary();
    hi = 0;
    repeat (PER) begin
      hi += int'(pos_motor[3]);
      cycle();
    end
    chk("t4_duty30", 32'(hi), 32'(30 * P));
    send(3, 0, 1, DRIVE);
    align_boundary();
    hi = 0;
    repeat (PER) begin
      hi += int'(pos_motor[3]);
      cycle();
    end
    chk("t4_duty0", 32'(hi), 32'd0);
    send(3, 255, 1, DRIVE);
    align_boundary();
    lo = 0;
    repeat (PER) begin
      lo += int'(!pos_motor[3]);
      cycle();
    end
    chk("t4_duty255_low", 32'(lo), 32'(P));

    // 5: out-of-range channel
    send(12, 99, 1, BRAKE);
    chk("t5_err_pulse", 32'(cmd_err), 32'd1);
    cycle();
    chk("t5_err_clear", 32'(cmd_err), 32'd0);
    align_boundary();
    chk("t5_ch0_unchanged", 32'(neg_motor[0]), 32'd1);

    // Write coinciding with the boundary tick waits a full period
    align_pre_boundary();
    send(4, 100, 0, DRIVE);
    chk("wb_not_yet", 32'(neg_motor[4]), 32'd0);
    run(10);
    chk("wb_still_off", 32'(neg_motor[4]), 32'd0);
    align_boundary();
    chk("wb_applied", 32'(neg_motor[4]), 32'd1);

    // Randomized commands, every cycle checked against the model
    repeat (6 * PER) begin
      if ($urandom_range(0, 149) == 0)
        send(int'($urandom_range(0, 9)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      else
        cycle();
    end

    // 6: reset during DEAD and during a PWM high phase
    send(0, 64, 0, DRIVE);
    send(1, 128, 0, DRIVE);
    align_boundary();
    align_boundary();
    send(1, 128, 1, DRIVE);
    align_boundary();
    run(2);
    chk("t6_pre_neg0", 32'(neg_motor[0]), 32'd1);
    chk("t6_pre_dead1", 32'({pos_motor[1], neg_motor[1]}), 32'd0);
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all();
    run(2);
    @(negedge osc_clk) rstn = 1'b1;
    chk("t6_ready_low", 32'(cmd_ready), 32'd0);
    cycle();
    chk("t6_ready_back", 32'(cmd_ready), 32'd1);

    send(0, 64, 0, DRIVE);
    align_boundary();
    run(5);
    chk("t6_pre_neg0_b", 32'(neg_motor[0]), 32'd1);
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all();
    chk("t6_neg0_zero", 32'(neg_motor[0]), 32'd0);
    run(1);
    @(negedge osc_clk) rstn = 1'b1;
    cycle();
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
